// File: rtl/alu_pkg.sv
// Shared ALU / mul-div sequencer definitions: ALU opcodes, sequencer
// state encoding and multiply/divide op select.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // Opcode presented while the sequencer does not own the ALU.
    localparam logic [3:0] ALU_IDLE = ALU_AND;

    localparam logic MD_MUL = 1'b0;
    localparam logic MD_DIV = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } md_state_t;

endpackage

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle multiply (shift-add) / divide (restoring) sequencer that
// borrows the shared EX-stage ALU while busy.
// Optional macro ALU_MULDIV_SIGNED_EN adds the op_signed port and
// sign/magnitude handling around the unsigned core.
module alu_muldiv_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
`ifdef ALU_MULDIV_SIGNED_EN
    input  logic             op_signed,
`endif
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [3:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo
);

    md_state_t        state_q, state_n;
    logic [CNT_W-1:0] cnt_q;
    logic             op_q;
    logic [WIDTH-1:0] opnd_q;          // multiplicand or divisor
    logic [WIDTH-1:0] hi_q, lo_q;      // {hi, lo} or {rem, quo}
    logic [WIDTH-1:0] hi_n, lo_n;
    logic [WIDTH-1:0] fin_hi, fin_lo;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] rs;
    logic             carry, msb, qbit;
    logic             div_zero;

    assign div_zero = (op == MD_DIV) && (operand_b == '0);

`ifdef ALU_MULDIV_SIGNED_EN
    logic neg_q, rem_neg_q;
    // Magnitudes formed locally so the ALU is never needed at acceptance.
    assign a_mag = (op_signed && operand_a[WIDTH-1]) ? -operand_a : operand_a;
    assign b_mag = (op_signed && operand_b[WIDTH-1]) ? -operand_b : operand_b;
`else
    assign a_mag = operand_a;
    assign b_mag = operand_b;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_n;
    end

    // Next state and handshake outputs; start is only honoured in IDLE.
    always_comb begin
        state_n = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: if (start) state_n = div_zero ? ST_DONE : ST_RUN;
            ST_RUN: begin
                busy = 1'b1;
                if (cnt_q == '0) state_n = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // One shift-add or restoring-divide step using the external ALU.
    always_comb begin
        alu_opcode = ALU_IDLE;
        alu_in1    = '0;
        alu_in2    = '0;
        hi_n       = hi_q;
        lo_n       = lo_q;
        carry      = 1'b0;
        msb        = 1'b0;
        rs         = '0;
        qbit       = 1'b0;
        if (state_q == ST_RUN) begin
            if (op_q == MD_MUL) begin
                alu_opcode = ALU_ADD;
                alu_in1    = hi_q;
                alu_in2    = lo_q[0] ? opnd_q : '0;
                // Wrap-around of an unsigned add reveals the lost carry.
                carry      = (alu_result < hi_q);
                hi_n       = {carry, alu_result[WIDTH-1:1]};
                lo_n       = {alu_result[0], lo_q[WIDTH-1:1]};
            end else begin
                {msb, rs}  = {hi_q, lo_q[WIDTH-1]};
                alu_opcode = ALU_SUB;
                alu_in1    = rs;
                alu_in2    = opnd_q;
                qbit       = msb | (rs >= opnd_q);
                hi_n       = qbit ? alu_result : rs;
                lo_n       = {lo_q[WIDTH-2:0], qbit};
            end
        end
    end

    // Final result, with sign correction when signed mode is built in.
    always_comb begin
        fin_hi = hi_n;
        fin_lo = lo_n;
`ifdef ALU_MULDIV_SIGNED_EN
        if (op_q == MD_MUL) begin
            if (neg_q) {fin_hi, fin_lo} = -{hi_n, lo_n};
        end else begin
            if (neg_q)     fin_lo = -lo_n;
            if (rem_neg_q) fin_hi = -hi_n;
        end
`endif
    end

    // Operand capture, iteration registers and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            op_q      <= MD_MUL;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            result_hi <= '0;
            result_lo <= '0;
`ifdef ALU_MULDIV_SIGNED_EN
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: if (start) begin
                    op_q   <= op;
                    cnt_q  <= CNT_W'(WIDTH - 1);
                    hi_q   <= '0;
                    lo_q   <= (op == MD_DIV) ? a_mag : b_mag;
                    opnd_q <= (op == MD_DIV) ? b_mag : a_mag;
`ifdef ALU_MULDIV_SIGNED_EN
                    neg_q     <= op_signed & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
                    rem_neg_q <= op_signed & operand_a[WIDTH-1];
`endif
                    // Divide by zero skips RUN: raw dividend, no sign fixup.
                    if (div_zero) begin
                        result_hi <= operand_a;
                        result_lo <= '1;
                    end
                end
                ST_RUN: begin
                    hi_q <= hi_n;
                    lo_q <= lo_n;
                    if (cnt_q == '0) begin
                        result_hi <= fin_hi;
                        result_lo <= fin_lo;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq: behavioural ALU, arithmetic
// reference (a*b, a/b, a%b) and cycle-level handshake expectations.
module tb_alu_muldiv_seq;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst, start, op;
    logic [W-1:0]  operand_a, operand_b;
    logic [3:0]    alu_opcode;
    logic [W-1:0]  alu_in1, alu_in2, alu_result;
    logic          busy, done;
    logic [W-1:0]  result_hi, result_lo;
`ifdef ALU_MULDIV_SIGNED_EN
    logic          op_signed = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Shared ALU stand-in, combinational.
    always_comb begin
        case (alu_opcode)
            4'b0000: alu_result = alu_in1 & alu_in2;
            4'b0001: alu_result = alu_in1 | alu_in2;
            4'b0010: alu_result = alu_in1 + alu_in2;
            4'b0110: alu_result = alu_in1 - alu_in2;
            4'b0111: alu_result = {31'd0, $signed(alu_in1) < $signed(alu_in2)};
            default: alu_result = '0;
        endcase
    end

    alu_muldiv_seq #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
`ifdef ALU_MULDIV_SIGNED_EN
        .op_signed(op_signed),
`endif
        .operand_a(operand_a), .operand_b(operand_b),
        .alu_opcode(alu_opcode), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_result(alu_result), .busy(busy), .done(done),
        .result_hi(result_hi), .result_lo(result_lo)
    );

    // Issue one request and observe 40 cycles after the accepting edge.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic o,
                          output logic [W-1:0] rh, output logic [W-1:0] rl,
                          output int dcyc, output int bcnt, output int dcnt, output int opc_bad);
        @(negedge clk);
        operand_a = a; operand_b = b; op = o; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        dcyc = -1; bcnt = 0; dcnt = 0; opc_bad = 0; rh = '0; rl = '0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (busy) begin
                bcnt++;
                if (alu_opcode !== (o ? 4'b0110 : 4'b0010)) opc_bad++;
            end else if (alu_opcode !== 4'b0000 || alu_in1 !== '0 || alu_in2 !== '0) opc_bad++;
            if (done) begin
                dcnt++;
                if (dcyc < 0) begin dcyc = c; rh = result_hi; rl = result_lo; end
            end
        end
    endtask

    // Reference outcome for one request.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic o,
                                  output logic [W-1:0] eh, output logic [W-1:0] el,
                                  output int edc, output int ebc);
        logic [2*W-1:0] p;
        if (!o) begin
            p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            eh = p[2*W-1:W]; el = p[W-1:0]; edc = W + 1; ebc = W;
        end else if (b == '0) begin
            eh = a; el = '1; edc = 1; ebc = 0;
        end else begin
            eh = a % b; el = a / b; edc = W + 1; ebc = W;
        end
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = 1'b0; operand_a = '0; operand_b = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL reset_hs busy=%b done=%b want 0 0", busy, done);
        end
        total++;
        if (result_hi !== '0 || result_lo !== '0) begin
            bad++; $display("FAIL reset_res hi=%h lo=%h want 0 0", result_hi, result_lo);
        end
        total++;
        if (alu_opcode !== 4'b0000 || alu_in1 !== '0 || alu_in2 !== '0) begin
            bad++; $display("FAIL reset_alu op=%b in1=%h in2=%h want 0", alu_opcode, alu_in1, alu_in2);
        end
    endtask

    // Run a list of requests, comparing results, latency and ALU use.
    task automatic test_ops(input string name, input logic [W-1:0] av[$], input logic [W-1:0] bv[$],
                            input logic o);
        logic [W-1:0] rh, rl, eh, el;
        int dc, bc, dn, ob, edc, ebc;
        foreach (av[i]) begin
            run_op(av[i], bv[i], o, rh, rl, dc, bc, dn, ob);
            model(av[i], bv[i], o, eh, el, edc, ebc);
            total++;
            if (rh !== eh || rl !== el) begin
                bad++;
                $display("FAIL %s_result a=%h b=%h got hi=%h lo=%h want hi=%h lo=%h",
                         name, av[i], bv[i], rh, rl, eh, el);
            end
            total++;
            if (dc != edc || bc != ebc || dn != 1) begin
                bad++;
                $display("FAIL %s_timing a=%h b=%h got done_cyc=%0d busy=%0d pulses=%0d want %0d %0d 1",
                         name, av[i], bv[i], dc, bc, dn, edc, ebc);
            end
            total++;
            if (ob != 0) begin
                bad++; $display("FAIL %s_alu_opcode a=%h b=%h bad_cycles=%0d want 0", name, av[i], bv[i], ob);
            end
            total++;
            if (result_hi !== eh || result_lo !== el) begin
                bad++;
                $display("FAIL %s_hold got hi=%h lo=%h want hi=%h lo=%h", name, result_hi, result_lo, eh, el);
            end
        end
    endtask

    task automatic test_mul();
        logic [W-1:0] av[$], bv[$];
        av = '{32'd7, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000};
        bv = '{32'd6, 32'hFFFF_FFFF, 32'h1234_5678, 32'd2};
        for (int i = 0; i < 12; i++) begin av.push_back($urandom); bv.push_back($urandom); end
        test_ops("mul", av, bv, 1'b0);
    endtask

    task automatic test_div();
        logic [W-1:0] av[$], bv[$];
        av = '{32'd100, 32'h8000_0000, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        bv = '{32'd7, 32'd1, 32'd9, 32'hFFFF_FFFF, 32'd3};
        for (int i = 0; i < 12; i++) begin
            av.push_back($urandom);
            bv.push_back((i % 3 == 0) ? $urandom_range(1, 255) : $urandom | 32'd1);
        end
        test_ops("div", av, bv, 1'b1);
    endtask

    task automatic test_div_zero();
        logic [W-1:0] av[$], bv[$];
        av = '{32'd123, 32'hDEAD_BEEF};
        bv = '{32'd0, 32'd0};
        test_ops("divz", av, bv, 1'b1);
    endtask

    // A start during RUN (cycle 10) and during DONE must both be dropped.
    task automatic test_start_ignored();
        int dn = 0, bc = 0, after_busy = 0;
        logic [W-1:0] rh = '0, rl = '0;
        @(negedge clk);
        operand_a = 32'd7; operand_b = 32'd6; op = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 10 || c == 33) begin
                operand_a = 32'd99; operand_b = 32'd0; op = 1'b1; start = 1'b1;
            end
            @(negedge clk);
            if (busy) begin
                bc++;
                if (c > 33) after_busy++;
            end
            if (done) begin dn++; rh = result_hi; rl = result_lo; end
            @(posedge clk);
            #1 start = 1'b0;
        end
        total++;
        if (dn != 1 || bc != 32 || after_busy != 0) begin
            bad++; $display("FAIL ignore_start pulses=%0d busy=%0d late_busy=%0d want 1 32 0", dn, bc, after_busy);
        end
        total++;
        if (rh !== 32'd0 || rl !== 32'd42 || result_lo !== 32'd42) begin
            bad++; $display("FAIL ignore_result hi=%h lo=%h want 0 0000002a", rh, rl);
        end
    endtask

    // Reset in cycle 15 of a divide aborts it; a fresh request then works.
    task automatic test_reset_midrun();
        int dn = 0;
        logic [W-1:0] rh, rl;
        int dc, bc, dpul, ob;
        @(negedge clk);
        operand_a = 32'd1000; operand_b = 32'd3; op = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (done) dn++;
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || dn != 0) begin
            bad++; $display("FAIL rst_mid_hs busy=%b done=%b early=%0d want 0 0 0", busy, done, dn);
        end
        total++;
        if (result_hi !== '0 || result_lo !== '0 || alu_opcode !== 4'b0000) begin
            bad++; $display("FAIL rst_mid_res hi=%h lo=%h op=%b want 0 0 0", result_hi, result_lo, alu_opcode);
        end
        dn = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done || busy) dn++;
        end
        total++;
        if (dn != 0) begin
            bad++; $display("FAIL rst_mid_quiet active_cycles=%0d want 0", dn);
        end
        run_op(32'd100, 32'd7, 1'b1, rh, rl, dc, bc, dpul, ob);
        total++;
        if (rh !== 32'd2 || rl !== 32'd14 || dc != 33 || dpul != 1) begin
            bad++; $display("FAIL rst_mid_fresh hi=%h lo=%h done_cyc=%0d pulses=%0d want 2 14 33 1", rh, rl, dc, dpul);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_zero();
        test_start_ignored();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Multi-cycle multiply/divide sequencer. It borrows the shared 32-bit ALU and drives its opcode and operand inputs once per cycle.
- Unsigned 32x32->64 multiply uses shift-add. Unsigned 32/32 divide uses restoring division. Each completes in WIDTH iterations.
- Sits beside the EX stage. The EX stage owns the ALU whenever busy is low.
- Start/busy/done handshake toward the pipeline hazard logic.

Parameters:
- WIDTH, 32, operand width. Must equal the ALU data width.
- CNT_W, 6, iteration counter width. Must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- op  input  1  0 = multiply, 1 = divide
- operand_a  input  WIDTH  multiplicand / dividend
- operand_b  input  WIDTH  multiplier / divisor
- alu_opcode  output  4  to ALU: 4'b0010 add, 4'b0110 sub, 4'b0000 when idle
- alu_in1  output  WIDTH  ALU operand 1
- alu_in2  output  WIDTH  ALU operand 2
- alu_result  input  WIDTH  ALU data_out, combinational same cycle
- busy  output  1  high while in RUN; ALU owned by this block
- done  output  1  one-cycle completion pulse
- result_hi  output  WIDTH  product[63:32] / remainder
- result_lo  output  WIDTH  product[31:0] / quotient

Behaviour:
- Reset (synchronous, rst high at edge): state IDLE, busy=0, done=0, result_hi=result_lo=0, counter=0, internal registers cleared. Reset mid-RUN aborts with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE: if start=1 at edge, latch op and operands, load counter=WIDTH-1, go to RUN.
  - Exception: op=1 with operand_b=0 goes to DONE directly with quotient=all ones, remainder=operand_a.
- RUN: one iteration per cycle. At counter==0, the edge goes to DONE. Otherwise decrement.
- DONE: done=1 for exactly one cycle, results registered. Next edge returns to IDLE. A start seen in DONE is ignored.
- Latency: start sampled at edge 0 -> busy high cycles 1..WIDTH -> done high in cycle WIDTH+1. Divide by zero: done in cycle 1.
- start while busy or done is ignored, with no queuing.
- Multiply datapath, regs {hi, lo}, lo initialised to the multiplier, hi=0:
  - alu_opcode=add, alu_in1=hi, alu_in2 = lo[0] ? multiplicand : 0.
  - carry = (alu_result < hi), unsigned, computed locally.
  - Next {hi, lo} = {carry, alu_result, lo} >> 1.
- Divide datapath, regs rem, quo, quo initialised to the dividend, rem=0:
  - Shift: {msb, rs} = {rem, quo[WIDTH-1]}.
  - alu_opcode=sub, alu_in1=rs, alu_in2=divisor.
  - If msb | (rs >= divisor): rem = alu_result, bit = 1. Else rem = rs, bit = 0.
  - quo = {quo[WIDTH-2:0], bit}.
- Outside RUN: alu_opcode=4'b0000, alu_in1=alu_in2=0.
- result_hi and result_lo update only on entry to DONE. They hold until the next completion.

Optional Feature:
- Macro: ALU_MULDIV_SIGNED_EN.
- When defined:
  - Adds input port op_signed (1 bit), sampled with start.
  - If set, operands are converted to magnitudes on acceptance, using local negation rather than the ALU.
  - On entry to DONE, the product is negated if the signs differ. The quotient is negated if the signs differ. The remainder takes the dividend's sign.
  - Latency is unchanged.
  - Divide by zero gives quotient=all ones and remainder=operand_a, with no fixup.
- When undefined: port absent, unsigned only.

Decomposition:
- Shared package alu_pkg:
  - ALU opcode constants ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_SLT=4'b0111.
  - State encoding for IDLE/RUN/DONE.
  - MD_MUL/MD_DIV op codes.
- No sub-module. Single FSM plus datapath registers. The ALU stays external.

Test Plan:
- Multiply 7 x 6 -> done in cycle 33, hi=0, lo=42. busy high cycles 1-32, alu_opcode=0010 throughout.
- Multiply 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Exercises the carry path.
- Divide 100 / 7 -> lo=14, hi=2. Divide 0x80000000 / 1 -> lo=0x80000000, hi=0. Divide 5 / 9 -> lo=0, hi=5.
- Divide 123 / 0 -> done in cycle 1, lo=0xFFFFFFFF, hi=123, busy never asserted.
- start pulsed in cycle 10 of a multiply -> ignored. Results match the first request, done pulses exactly once.
- rst asserted in cycle 15 of a divide -> next cycle IDLE, busy=0, done=0, results=0. A fresh start then completes normally.
